// File: rtl/piso_serializer.sv
// piso_serializer: captures a WIDTH-bit word on load_valid/load_ready and shifts it out MSB-first, first bit one cycle after accept.
// load_ready is high only when idle or on the final frame bit (back-to-back reload); `define PARITY_EN appends an even-parity bit.
module piso_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] d_in,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

`ifdef PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1
  } state_t;
`endif

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] shift_reg;
  logic [WIDTH-1:0] shift_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             ser_out_nxt;
  logic             ser_valid_nxt;
  logic             done_nxt;
  logic             last_bit;
  logic             accept;
`ifdef PARITY_EN
  logic             par_reg;
  logic             par_nxt;
`endif

  // The last bit of a frame is the only busy cycle that may accept the next word.
`ifdef PARITY_EN
  assign last_bit = (state == PARITY);
`else
  assign last_bit = (state == SHIFT) && (cnt == '0);
`endif

  assign load_ready = (state == IDLE) || last_bit;
  assign accept     = load_valid && load_ready;

  always_comb begin
    state_nxt = state;
    shift_nxt = shift_reg;
    cnt_nxt   = cnt;
`ifdef PARITY_EN
    par_nxt   = par_reg;
`endif
    case (state)
      IDLE: begin
        state_nxt = IDLE;
      end
      SHIFT: begin
        shift_nxt = {shift_reg[WIDTH-2:0], 1'b0};
        if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
`ifdef PARITY_EN
          state_nxt = PARITY;
`else
          state_nxt = IDLE;
`endif
        end
      end
`ifdef PARITY_EN
      PARITY: begin
        state_nxt = IDLE;
      end
`endif
      default: begin
        state_nxt = IDLE;
      end
    endcase

    // accept can only be true in IDLE or the last-bit cycle, so it overrides the returns above.
    if (accept) begin
      state_nxt = SHIFT;
      shift_nxt = d_in;
      cnt_nxt   = LAST_IDX;
`ifdef PARITY_EN
      par_nxt   = ^d_in;
`endif
    end
  end

  // Registered outputs are a function of the next state so they line up with it after the edge.
  always_comb begin
    ser_valid_nxt = (state_nxt != IDLE);
    ser_out_nxt   = 1'b0;
    done_nxt      = 1'b0;
    if (state_nxt == SHIFT) begin
      ser_out_nxt = shift_nxt[WIDTH-1];
`ifndef PARITY_EN
      done_nxt    = (cnt_nxt == '0);
`endif
    end
`ifdef PARITY_EN
    if (state_nxt == PARITY) begin
      ser_out_nxt = par_nxt;
      done_nxt    = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      shift_reg <= '0;
      cnt       <= '0;
      ser_out   <= 1'b0;
      ser_valid <= 1'b0;
      done      <= 1'b0;
`ifdef PARITY_EN
      par_reg   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      shift_reg <= shift_nxt;
      cnt       <= cnt_nxt;
      ser_out   <= ser_out_nxt;
      ser_valid <= ser_valid_nxt;
      done      <= done_nxt;
`ifdef PARITY_EN
      par_reg   <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer (WIDTH=8): directed scenarios plus a randomized run against a queue-based model.
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PARITY_EN
  localparam int FL = W + 1;
`else
  localparam int FL = W;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] d_in = '0;
  logic         ser_out;
  logic         ser_valid;
  logic         done;

  int total = 0;
  int passed = 0;

  typedef struct packed {
    logic b;
    logic d;
  } ent_t;

  piso_serializer #(.WIDTH(W)) dut (
    .clk(clk),
    .reset(reset),
    .load_valid(load_valid),
    .load_ready(load_ready),
    .d_in(d_in),
    .ser_out(ser_out),
    .ser_valid(ser_valid),
    .done(done)
  );

  always #5 clk = ~clk;

  // Bit k (1-based) of the frame for word w: data MSB-first, then the even-parity bit if enabled.
  function automatic logic frame_bit(input logic [W-1:0] w, input int k);
    if (k <= W) return w[W-k];
    return ^w;
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    load_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    total++; if (ser_valid !== 1'b0) $display("FAIL reset_ser_valid got %b exp 0", ser_valid); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done got %b exp 0", done); else passed++;
    total++; if (ser_out !== 1'b0) $display("FAIL reset_ser_out got %b exp 0", ser_out); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL reset_load_ready got %b exp 1", load_ready); else passed++;
  endtask

  task automatic test_single(input logic [W-1:0] w);
    logic exp_last;
    total++; if (load_ready !== 1'b1) $display("FAIL single_ready_idle w=%h got %b exp 1", w, load_ready); else passed++;
    load_valid = 1'b1;
    d_in = w;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      d_in = '0;
      exp_last = (k == FL);
      total++; if (ser_valid !== 1'b1) $display("FAIL single_valid w=%h k=%0d got %b exp 1", w, k, ser_valid); else passed++;
      total++; if (ser_out !== frame_bit(w, k)) $display("FAIL single_bit w=%h k=%0d got %b exp %b", w, k, ser_out, frame_bit(w, k)); else passed++;
      total++; if (done !== exp_last) $display("FAIL single_done w=%h k=%0d got %b exp %b", w, k, done, exp_last); else passed++;
      total++; if (load_ready !== exp_last) $display("FAIL single_ready w=%h k=%0d got %b exp %b", w, k, load_ready, exp_last); else passed++;
    end
    @(negedge clk);
    total++; if (ser_valid !== 1'b0) $display("FAIL single_after_valid w=%h got %b exp 0", w, ser_valid); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL single_after_ready w=%h got %b exp 1", w, load_ready); else passed++;
    total++; if (done !== 1'b0) $display("FAIL single_after_done w=%h got %b exp 0", w, done); else passed++;
  endtask

  task automatic test_back_to_back(input logic [W-1:0] w0, input logic [W-1:0] w1);
    logic exp_bit;
    logic exp_done;
    load_valid = 1'b1;
    d_in = w0;
    for (int k = 1; k <= 2 * FL; k++) begin
      @(negedge clk);
      exp_bit = (k <= FL) ? frame_bit(w0, k) : frame_bit(w1, k - FL);
      exp_done = (k == FL) || (k == 2 * FL);
      total++; if (ser_valid !== 1'b1) $display("FAIL b2b_valid k=%0d got %b exp 1", k, ser_valid); else passed++;
      total++; if (ser_out !== exp_bit) $display("FAIL b2b_bit k=%0d got %b exp %b", k, ser_out, exp_bit); else passed++;
      total++; if (done !== exp_done) $display("FAIL b2b_done k=%0d got %b exp %b", k, done, exp_done); else passed++;
      d_in = w1;
      load_valid = (k <= FL);
    end
    @(negedge clk);
    total++; if (ser_valid !== 1'b0) $display("FAIL b2b_after_valid got %b exp 0", ser_valid); else passed++;
  endtask

  task automatic test_ignore_busy(input logic [W-1:0] w, input logic [W-1:0] intruder);
    load_valid = 1'b1;
    d_in = w;
    for (int k = 1; k <= FL; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      d_in = '0;
      total++; if (ser_out !== frame_bit(w, k)) $display("FAIL ignore_bit k=%0d got %b exp %b", k, ser_out, frame_bit(w, k)); else passed++;
      if (k == 3) begin
        total++; if (load_ready !== 1'b0) $display("FAIL ignore_ready k=3 got %b exp 0", load_ready); else passed++;
        load_valid = 1'b1;
        d_in = intruder;
      end
    end
    @(negedge clk);
    total++; if (ser_valid !== 1'b0) $display("FAIL ignore_after_valid got %b exp 0", ser_valid); else passed++;
  endtask

  task automatic test_reset_mid_frame(input logic [W-1:0] w, input logic [W-1:0] w_next);
    load_valid = 1'b1;
    d_in = w;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      load_valid = 1'b0;
      total++; if (ser_out !== frame_bit(w, k)) $display("FAIL midrst_bit k=%0d got %b exp %b", k, ser_out, frame_bit(w, k)); else passed++;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    total++; if (ser_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", ser_valid); else passed++;
    total++; if (done !== 1'b0) $display("FAIL midrst_done got %b exp 0", done); else passed++;
    total++; if (ser_out !== 1'b0) $display("FAIL midrst_ser_out got %b exp 0", ser_out); else passed++;
    total++; if (load_ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", load_ready); else passed++;
    test_single(w_next);
  endtask

  // Model: a queue of pending output cycles; the head is what the DUT shows this cycle.
  task automatic test_random(input int cycles);
    ent_t q[$];
    logic exp_valid;
    logic exp_bit;
    logic exp_done;
    logic exp_ready;
    logic [W-1:0] w;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      exp_valid = (q.size() > 0);
      exp_bit = exp_valid ? q[0].b : 1'b0;
      exp_done = exp_valid ? q[0].d : 1'b0;
      exp_ready = (q.size() <= 1);
      total++; if (ser_valid !== exp_valid) $display("FAIL rand_valid c=%0d got %b exp %b", c, ser_valid, exp_valid); else passed++;
      total++; if (ser_out !== exp_bit) $display("FAIL rand_bit c=%0d got %b exp %b", c, ser_out, exp_bit); else passed++;
      total++; if (done !== exp_done) $display("FAIL rand_done c=%0d got %b exp %b", c, done, exp_done); else passed++;
      total++; if (load_ready !== exp_ready) $display("FAIL rand_ready c=%0d got %b exp %b", c, load_ready, exp_ready); else passed++;
      w = W'($urandom);
      load_valid = ($urandom_range(0, 3) != 0);
      d_in = w;
      reset = ($urandom_range(0, 39) == 0);
      if (reset) begin
        q.delete();
      end else begin
        if (q.size() > 0) void'(q.pop_front());
        if (load_valid && exp_ready) begin
          for (int k = 1; k <= FL; k++) q.push_back('{b: frame_bit(w, k), d: (k == FL)});
        end
      end
    end
    load_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single(8'hA5);
    test_back_to_back(8'hA5, 8'h3C);
    test_ignore_busy(8'h81, 8'hFF);
    test_reset_mid_frame(8'hF0, 8'h0F);
    test_single(8'hA5);
    test_single(8'h07);
    test_random(600);
    test_single(8'h5A);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
